// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: state encoding shared by the serial adder controller and its users.
package serial_adder_ctrl_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// fulladder: the shared 1-bit full-adder cell time-shared by serial_adder_ctrl.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands LSB first through one fulladder cell.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
    logic [CW-1:0]    cnt;
    logic             carry, fa_sum, fa_cout;
    fulladder u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign acc_next = WIDTH'({fa_sum, acc} >> 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       busy1, done1, cout1, sum1;
    int         tests = 0, fails = 0;
    logic [1:0] fa_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept on the next edge, expect busy for 7 more edges and done on the 8th.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [8:0] exp);
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_accept"}, {busy, done}, 2'b10);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk({tag, "_run"}, {busy, done}, 2'b10);
        end
        tick();
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_result"}, {cout, sum}, exp);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_outputs", {busy, done, cout, sum}, 0);
        chk("reset_outputs_w1", {busy1, done1, cout1, sum1}, 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {busy, done}, 2'b00);

        run8("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        run8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
        run8("all_ones", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run8("mixed", 8'h5A, 8'h3C, 1'b1, 9'h097);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold", {busy, done, cout, sum}, {3'b000, 8'h97});
        end

        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        chk("held_start_accept", {busy, done}, 2'b10);
        for (int i = 1; i < 8; i++) begin
            if (i == 4) begin a = 8'hFF; b = 8'hFF; end
            tick();
            chk("held_start_run", {busy, done, cout, sum}, {2'b10, 9'h097});
        end
        tick();
        chk("first_done", {busy, done}, 2'b01);
        chk("first_result", {cout, sum}, 9'h033);
        tick();
        start = 1'b0;
        chk("back_to_back", {busy, done}, 2'b10);
        for (int i = 2; i < 9; i++) begin
            tick();
            chk("second_run", {busy, done}, 2'b10);
        end
        tick();
        chk("second_done_9", {busy, done}, 2'b01);
        chk("second_result", {cout, sum}, 9'h1FE);

        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_abort_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, cout, sum}, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_done_after_abort", {busy, done}, 2'b00);
        end
        run8("after_abort", 8'h01, 8'h01, 1'b0, 9'h002);

        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_accept", {busy1, done1}, 2'b10);
            tick();
            chk("w1_done", {busy1, done1}, 2'b01);
            chk("w1_result", {cout1, sum1}, fa_tbl[i]);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
